// File: rtl/draw_arbiter_if.sv
// Plot-port handshake bundle between the sprite requesters and draw_arbiter.
// master = requester/controller side, slave = arbiter side.
interface draw_arbiter_if #(
    parameter int unsigned CNT_W = 5
);
    logic             req_self;
    logic             req_enemy;
    logic             datapath_select;
    logic             plot;
    logic [CNT_W-1:0] pix_cnt;
    logic             done_self;
    logic             done_enemy;
    logic             busy;

    modport master (
        output req_self, req_enemy,
        input  datapath_select, plot, pix_cnt, done_self, done_enemy, busy
    );

    modport slave (
        input  req_self, req_enemy,
        output datapath_select, plot, pix_cnt, done_self, done_enemy, busy
    );
endinterface

// File: rtl/draw_arbiter.sv
// Grants the single VGA plot port to the self or enemy sprite datapath and sequences pix_cnt.
// Optional macro DRAW_ARBITER_ROUND_ROBIN_EN: alternate grants on ties (default: self always wins).
module draw_arbiter #(
    parameter int unsigned PIXELS = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic           clk,
    input  logic           resetn,
    draw_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             done_self_q, done_self_d;
    logic             done_enemy_q, done_enemy_d;

    logic any_req_c;
    logic grant_c;

    // Tie resolution: grant_c = 1 selects the enemy datapath.
    always_comb begin
        any_req_c = bus.req_self | bus.req_enemy;
`ifdef DRAW_ARBITER_ROUND_ROBIN_EN
        grant_c = (bus.req_self & bus.req_enemy) ? ~last_q : ~bus.req_self;
`else
        grant_c = ~bus.req_self;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req_c) state_d = DRAW;
            DRAW:    if (pix_cnt_q == LAST_PIX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port is a flop.
    always_comb begin
        sel_d        = sel_q;
        last_d       = last_q;
        pix_cnt_d    = '0;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_self_d  = 1'b0;
        done_enemy_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    sel_d  = grant_c;
                    plot_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
            DRAW: begin
                busy_d = 1'b1;
                if (pix_cnt_q == LAST_PIX) begin
                    done_self_d  = ~sel_q;
                    done_enemy_d = sel_q;
                end else begin
                    plot_d    = 1'b1;
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
            end
            DONE:    last_d = sel_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            pix_cnt_q    <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_self_q  <= 1'b0;
            done_enemy_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            last_q       <= last_d;
            pix_cnt_q    <= pix_cnt_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_self_q  <= done_self_d;
            done_enemy_q <= done_enemy_d;
        end
    end

    assign bus.datapath_select = sel_q;
    assign bus.plot            = plot_q;
    assign bus.pix_cnt         = pix_cnt_q;
    assign bus.busy            = busy_q;
    assign bus.done_self       = done_self_q;
    assign bus.done_enemy      = done_enemy_q;
endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Time-multiplexes the single VGA plot port between the self-object and enemy-object drawing datapaths. Each datapath requests a sprite draw; the arbiter grants one at a time, sequences the pixel-offset counter for that sprite, drives `plot` (the VGA write enable) and `datapath_select`, and returns a one-cycle done pulse to the served requester. It sits between the self and enemy controllers and the datapath mux, which selects x/y/colour by `datapath_select` (0 = self, 1 = enemy).

## Interface
Parameters:
- `PIXELS`, default 16: pixels per sprite draw; legal range 1 to 2^CNT_W.
- `CNT_W`, default 5: width of `pix_cnt`; must hold PIXELS-1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_self`  in  1  self controller requests a sprite draw; held until `done_self`.
- `req_enemy`  in  1  enemy controller requests a sprite draw; held until `done_enemy`.
- `datapath_select`  out  1  mux select: 0 = self, 1 = enemy.
- `plot`  out  1  VGA write enable; high once per pixel.
- `pix_cnt`  out  CNT_W  pixel offset within the sprite, consumed by the granted datapath.
- `done_self`  out  1  one-cycle pulse after the last self pixel.
- `done_enemy`  out  1  one-cycle pulse after the last enemy pixel.
- `busy`  out  1  high in DRAW and DONE.

## Operation
- All outputs are registered (Moore). Reset values: state IDLE, `datapath_select`=0, `plot`=0, `pix_cnt`=0, `done_*`=0, `busy`=0, last-grant register = enemy.
- IDLE: if no request, stay. If exactly one request is high, grant it. If both are high, apply the priority rule (see Configuration). Granting loads `datapath_select`, clears `pix_cnt`, and enters DRAW.
- DRAW: `plot`=1 and `busy`=1. `pix_cnt` increments by 1 per cycle from 0. In the cycle with `pix_cnt`==PIXELS-1, the next state is DONE.
- DONE: `plot`=0, `pix_cnt` returns to 0, and `done_<granted>`=1 for exactly this cycle. The last-grant register is updated. Next state is IDLE, unconditionally.
- `datapath_select` holds its granted value through DRAW and DONE, and keeps that value in IDLE until the next grant.
- Requester rule: the requester deasserts its request on the edge where it samples its done pulse. A request still high in IDLE is treated as a new request.
- A request dropped during DRAW is ignored; the draw completes and done still pulses.
- The other requester's request during DRAW or DONE is held pending and is served from the next IDLE.
- `pix_cnt` never exceeds PIXELS-1 and never wraps mid-draw.
- PIXELS=1 gives a single `plot` cycle.

## Timing
- A request high in IDLE at edge E gives DRAW from E+1.
- `plot` is high for PIXELS consecutive cycles. `pix_cnt` is 0..PIXELS-1 on those cycles.
- DONE occurs at E+PIXELS+1. IDLE occurs at E+PIXELS+2.
- Back-to-back grants take PIXELS+2 cycles each, because one IDLE cycle always separates them.
- Asynchronous reset asserted at any time, including mid-DRAW: all outputs go to their reset values immediately. No done pulse is issued for an aborted draw. The first grant after reset is evaluated at the first rising edge with `resetn` high.

## Configuration
- `DRAW_ARBITER_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, grant the requester that is not recorded in the last-grant register. After reset, self wins the first tie.
- Not defined: fixed priority; self always wins a tie, and the enemy can be starved. The last-grant register is still maintained but is not used.

## Test plan
- Reset values: hold `resetn`=0 with both requests high → all outputs 0, state IDLE. Release reset → self granted on the first edge.
- Single self draw, PIXELS=16, `req_self` rises at E → `plot` high E+1..E+16, `pix_cnt` 0..15, `datapath_select`=0, `done_self` pulse at E+17, `busy` low at E+18.
- Simultaneous requests with `DRAW_ARBITER_ROUND_ROBIN_EN`, both requesters re-requesting immediately after done → grant order self, enemy, self, enemy. Each done is 18 cycles after the previous one.
- Same stimulus without the macro → only self is served and `done_enemy` never pulses over 10 grants.
- Reset mid-draw: assert `resetn`=0 asynchronously when `pix_cnt`=7 → `plot` and `pix_cnt` go to 0 immediately and no `done_self` pulse is issued.
- Request dropped mid-draw: `req_self` low at `pix_cnt`=3 → the draw still completes 16 pixels and `done_self` pulses. A `req_enemy` arriving during that draw gets DRAW at DONE+2.
